// File: rtl/vec_mac_unit.sv
// Pipelined multi-lane signed multiply-accumulate with valid/ready result port.
// Define SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module vec_mac_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int LANES       = 4,
    parameter int ACCUM_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in1,
    input  logic [LANES*DATA_WIDTH-1:0]   in2,
    input  logic                          last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACCUM_WIDTH-1:0]        total,
    output logic                          err
);

    // state | meaning
    // IDLE  | accumulator zero, waiting for the first beat of a vector
    // ACCUM | vector in progress, beats accepted
    // DRAIN | last beat's products in flight to the accumulator
    // HOLD  | result presented, waiting for out_ready

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int BASE_W = (ACCUM_WIDTH > PROD_W) ? ACCUM_WIDTH : PROD_W;
    localparam int SUM_W  = BASE_W + $clog2(LANES) + 1;
    localparam int WIDE_W = SUM_W + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t state_q;
    state_t state_d;

    logic                          accept;
    logic                          pipe_valid;
    logic signed [DATA_WIDTH-1:0]  a_lane;
    logic signed [DATA_WIDTH-1:0]  b_lane;
    logic signed [PROD_W-1:0]      prod_d [LANES];
    logic signed [PROD_W-1:0]      prod_q [LANES];
    logic signed [SUM_W-1:0]       prod_sum;
    logic [WIDE_W-1:0]             acc_wide;
    logic [WIDE_W-ACCUM_WIDTH:0]   wide_top;
    logic                          ovf;
    logic signed [ACCUM_WIDTH-1:0] acc_q;
    logic [ACCUM_WIDTH-1:0]        acc_next;
    logic                          err_q;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = last ? DRAIN : ACCUM;
                ACCUM:   if (accept && last) state_d = DRAIN;
                DRAIN:   state_d = HOLD;
                HOLD:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && !clr;
        out_valid = (state_q == HOLD);
    end

    // Operands are sign-extended to full product width so each lane product is exact.
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            a_lane    = in1[i*DATA_WIDTH +: DATA_WIDTH];
            b_lane    = in2[i*DATA_WIDTH +: DATA_WIDTH];
            prod_d[i] = $signed({{DATA_WIDTH{a_lane[DATA_WIDTH-1]}}, a_lane})
                      * $signed({{DATA_WIDTH{b_lane[DATA_WIDTH-1]}}, b_lane});
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_sum = prod_sum + $signed({{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]});
        end
    end

    // The wide sum fits signed ACCUM_WIDTH only if all bits from the accumulator sign bit up agree.
    always_comb begin
        acc_wide = {{(WIDE_W-ACCUM_WIDTH){acc_q[ACCUM_WIDTH-1]}}, acc_q}
                 + {prod_sum[SUM_W-1], prod_sum};
        wide_top = acc_wide[WIDE_W-1:ACCUM_WIDTH-1];
        ovf      = !((&wide_top) || !(|wide_top));
`ifdef SATURATE_EN
        if (ovf) begin
            acc_next = acc_wide[WIDE_W-1] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
        end else begin
            acc_next = acc_wide[ACCUM_WIDTH-1:0];
        end
`else
        acc_next = acc_wide[ACCUM_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            err_q      <= 1'b0;
            pipe_valid <= 1'b0;
        end else if (clr) begin
            acc_q      <= '0;
            err_q      <= 1'b0;
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= accept;
            if ((state_q == HOLD) && out_ready) begin
                acc_q <= '0;
                err_q <= 1'b0;
            end else if (pipe_valid) begin
                acc_q <= acc_next;
                if (ovf) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign total = acc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_vec_mac_unit.sv
// Self-checking bench for vec_mac_unit: fixed vector table, corner sequences and random traffic
// compared each cycle against a transaction-level reference model (honours SATURATE_EN).
module tb_vec_mac_unit;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] total;
    logic        err;

    int checks;
    int errors;

    // reference model state
    logic signed [15:0] m_total;
    bit                 m_err;
    bit                 m_outv;
    bit                 m_pend_valid;
    bit                 m_pend_last;
    int                 m_pend_sum;

    typedef struct {
        string       name;
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [15:0] exp_total;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    vec_mac_unit #(.DATA_WIDTH(8), .LANES(4), .ACCUM_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .total     (total),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beat_sum(input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
        end
        return s;
    endfunction

    task automatic model_reset();
        m_total      = '0;
        m_err        = 1'b0;
        m_outv       = 1'b0;
        m_pend_valid = 1'b0;
        m_pend_last  = 1'b0;
        m_pend_sum   = 0;
    endtask

    task automatic model_add(input int s);
        longint wide;
        wide = longint'(m_total) + longint'(s);
        if (wide > 32767 || wide < -32768) begin
            m_err = 1'b1;
`ifdef SATURATE_EN
            m_total = (wide > 0) ? 16'sh7FFF : 16'sh8000;
`else
            m_total = wide[15:0];
`endif
        end else begin
            m_total = wide[15:0];
        end
    endtask

    // What the block does at one rising edge, given the inputs held across it.
    task automatic model_step();
        bit acc;
        if (clr) begin
            model_reset();
        end else begin
            acc = in_valid && !m_pend_last && !m_outv;
            if (m_outv && out_ready) begin
                m_total = '0;
                m_err   = 1'b0;
                m_outv  = 1'b0;
            end else if (m_pend_valid) begin
                model_add(m_pend_sum);
                if (m_pend_last) m_outv = 1'b1;
            end
            m_pend_valid = acc;
            m_pend_last  = acc && last;
            m_pend_sum   = beat_sum(in1, in2);
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit l, input bit ordy, input bit c);
        bit exp_rdy;
        @(negedge clk);
        chk("total", {16'h0, total}, {16'h0, m_total});
        chk("err", {31'h0, err}, {31'h0, m_err});
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_outv});
        in_valid  = v;
        in1       = a;
        in2       = b;
        last      = l;
        out_ready = ordy;
        clr       = c;
        exp_rdy   = !c && !m_pend_last && !m_outv;
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
        @(posedge clk);
        model_step();
    endtask

    task automatic run_vector(input vec_t t);
        for (int i = 0; i < t.n; i++) begin
            cycle(1'b1, t.a, t.b, (i == t.n - 1), 1'b0, 1'b0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk({t.name, "_total"}, {16'h0, total}, {16'h0, t.exp_total});
        chk({t.name, "_err"}, {31'h0, err}, {31'h0, t.exp_err});
        chk({t.name, "_out_valid"}, {31'h0, out_valid}, 32'h1);
        // offered beats during the hold must not disturb the frozen result
        for (int h = 0; h <= t.hold; h++) begin
            cycle(1'b1, $urandom, $urandom, 1'b1, (h == t.hold), 1'b0);
        end
        #1;
        chk({t.name, "_total_after_hs"}, {16'h0, total}, 32'h0);
        chk({t.name, "_ov_after_hs"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0] = '{"single_1x1", 1, 32'h01010101, 32'h01010101, 0, 16'h0004, 1'b0};
        tbl[1] = '{"ten_beats", 10, 32'h04030201, 32'h01010101, 5, 16'h0064, 1'b0};
`ifdef SATURATE_EN
        tbl[2] = '{"pos_ovf", 1, 32'h80808080, 32'h80808080, 1, 16'h7FFF, 1'b1};
        tbl[3] = '{"neg_ovf", 3, 32'h80808080, 32'h7F7F7F7F, 0, 16'h8000, 1'b1};
        tbl[4] = '{"pos_ovf_127", 1, 32'h7F7F7F7F, 32'h7F7F7F7F, 2, 16'h7FFF, 1'b1};
`else
        tbl[2] = '{"pos_ovf", 1, 32'h80808080, 32'h80808080, 1, 16'h0000, 1'b1};
        tbl[3] = '{"neg_ovf", 3, 32'h80808080, 32'h7F7F7F7F, 0, 16'h0600, 1'b1};
        tbl[4] = '{"pos_ovf_127", 1, 32'h7F7F7F7F, 32'h7F7F7F7F, 2, 16'hFC04, 1'b1};
`endif
        tbl[5] = '{"neg_small", 3, 32'hFFFFFFFF, 32'h05050505, 1, 16'hFFC4, 1'b0};

        // reset held with a beat offered on all-ones operands
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b1;
        in1       = 32'hFFFFFFFF;
        in2       = 32'hFFFFFFFF;
        last      = 1'b1;
        out_ready = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("rst_total", {16'h0, total}, 32'h0);
            chk("rst_err", {31'h0, err}, 32'h0);
            chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        for (int i = 0; i < 6; i++) begin
            run_vector(tbl[i]);
        end

        // clr mid-vector with a beat in flight and another offered
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h01010101, 32'h01010101, 1'b0, 1'b0, 1'b0);
        end
        #1;
        chk("clr_pre_total", {16'h0, total}, 32'h000C);
        cycle(1'b1, 32'h01010101, 32'h01010101, 1'b0, 1'b1, 1'b1);
        #1;
        chk("clr_total", {16'h0, total}, 32'h0);
        chk("clr_err", {31'h0, err}, 32'h0);
        run_vector('{"after_clr", 2, 32'h01010101, 32'h01010101, 0, 16'h0008, 1'b0});

        // reset mid-vector: no partial result may appear
        cycle(1'b1, 32'h02020202, 32'h02020202, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h02020202, 32'h02020202, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_total", {16'h0, total}, 32'h0);
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // random traffic, alternating small and full-range operands
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 200 < 100) begin
                a = a & 32'h87878787;
                b = b & 32'h07070707;
            end
            cycle(($urandom_range(0, 3) != 0), a, b, ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 39) == 0));
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
